// File: rtl/combo_lock_ctrl.sv
// ----------------------------------------------------------------------------
// combo_lock_ctrl
//   Combination-lock controller for debounced front-panel buttons. It opens on
//   a matching code, lets the user store a new code while open, counts
//   consecutive wrong codes and enters a timed ALARM lockout (with a blink
//   output) once MAX_TRIES is reached. OPEN and SET_WAIT relock on their own
//   after OPEN_CYCLES cycles.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   code_in     in   PW_W   code switches, sampled only on a button-event edge
//   enter_btn   in   1      enter / relock button (level)
//   set_btn     in   1      set-password button (level)
//   state_o     out  2      00 LOCKED, 01 OPEN, 10 SET_WAIT, 11 ALARM
//   unlocked    out  1      state is OPEN or SET_WAIT
//   alarm       out  1      state is ALARM
//   blink       out  1      toggles every BLINK_DIV cycles while in ALARM
//   tries_left  out  8      MAX_TRIES minus consecutive failed attempts
//
// Buttons are levels; a press is the first cycle a button is seen high, so a
// held button produces exactly one event. When enter and set rise together,
// enter wins and set is dropped. state_o doubles as the FSM debug view.
// ----------------------------------------------------------------------------
module combo_lock_ctrl #(
  parameter int              PW_W         = 7,
  parameter int              MAX_TRIES    = 3,
  parameter int              OPEN_CYCLES  = 500,
  parameter int              ALARM_CYCLES = 1000,
  parameter int              BLINK_DIV    = 100,
  parameter logic [PW_W-1:0] RESET_CODE   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PW_W-1:0] code_in,
  input  logic            enter_btn,
  input  logic            set_btn,
  output logic [1:0]      state_o,
  output logic            unlocked,
  output logic            alarm,
  output logic            blink,
  output logic [7:0]      tries_left
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'b00,
    ST_OPEN     = 2'b01,
    ST_SET_WAIT = 2'b10,
    ST_ALARM    = 2'b11
  } state_t;

  localparam int T_MAX = (OPEN_CYCLES > ALARM_CYCLES) ? OPEN_CYCLES : ALARM_CYCLES;
  localparam int T_W   = $clog2(T_MAX);
  localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [T_W-1:0]  OPEN_LOAD  = T_W'(OPEN_CYCLES - 1);
  localparam logic [T_W-1:0]  ALARM_LOAD = T_W'(ALARM_CYCLES - 1);
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_DIV - 1);
  localparam logic [7:0]      TRIES_MAX  = 8'(MAX_TRIES);

  state_t          r_state;
  logic [PW_W-1:0] r_pw;
  logic [7:0]      r_fail_cnt;
  logic [T_W-1:0]  r_timer;
  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink;
  logic            r_enter_q;
  logic            r_set_q;

  state_t          w_state_nxt;
  logic [PW_W-1:0] w_pw_nxt;
  logic [7:0]      w_fail_nxt;
  logic [7:0]      w_fail_inc;
  logic [T_W-1:0]  w_timer_nxt;
  logic [BC_W-1:0] w_blink_cnt_nxt;
  logic            w_blink_nxt;
  logic            w_ev_enter;
  logic            w_ev_set;

  assign w_ev_enter = enter_btn & ~r_enter_q;
  assign w_ev_set   = set_btn & ~r_set_q;
  assign w_fail_inc = r_fail_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOCKED;
      r_pw        <= RESET_CODE;
      r_fail_cnt  <= '0;
      r_timer     <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_enter_q   <= 1'b0;
      r_set_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pw        <= w_pw_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_timer     <= w_timer_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink     <= w_blink_nxt;
      r_enter_q   <= enter_btn;
      r_set_q     <= set_btn;
    end
  end

  // The timer is forced to 0 on every exit to LOCKED so it always reads 0
  // outside the timed states.
  always_comb begin
    w_state_nxt     = r_state;
    w_pw_nxt        = r_pw;
    w_fail_nxt      = r_fail_cnt;
    w_timer_nxt     = r_timer;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_nxt     = r_blink;
    case (r_state)
      ST_LOCKED: begin
        if (w_ev_enter) begin
          if (code_in == r_pw) begin
            w_state_nxt = ST_OPEN;
            w_timer_nxt = OPEN_LOAD;
            w_fail_nxt  = '0;
          end else begin
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc == TRIES_MAX) begin
              w_state_nxt     = ST_ALARM;
              w_timer_nxt     = ALARM_LOAD;
              w_blink_cnt_nxt = '0;
              w_blink_nxt     = 1'b0;
            end
          end
        end
      end
      ST_OPEN: begin
        if (w_ev_enter) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else if (w_ev_set) begin
          w_state_nxt = ST_SET_WAIT;
          w_timer_nxt = OPEN_LOAD;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_SET_WAIT: begin
        if (w_ev_enter) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else if (w_ev_set) begin
          w_pw_nxt    = code_in;
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_ALARM: begin
        if (r_timer == '0) begin
          w_state_nxt     = ST_LOCKED;
          w_fail_nxt      = '0;
          w_blink_nxt     = 1'b0;
          w_blink_cnt_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
          if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_blink_nxt     = ~r_blink;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign state_o    = r_state;
  assign unlocked   = (r_state == ST_OPEN) || (r_state == ST_SET_WAIT);
  assign alarm      = (r_state == ST_ALARM);
  assign blink      = r_blink;
  assign tries_left = TRIES_MAX - r_fail_cnt;

endmodule
